// File: rtl/jedro_1_lsu.sv
`default_nettype none
// ============================================================================
// Module   : jedro_1_lsu
// Brief    : Load-store unit of the jedro_1 core. Masters the data bus with a
//            req/gnt/rvalid handshake, steers store bytes onto their lanes and
//            aligns/extends load data for the register-file write port.
// Revision : 1.0 - initial release
// ============================================================================
module jedro_1_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      ctrl_valid_i,
  input  logic [3:0]                ctrl_i,
  input  logic [REG_ADDR_WIDTH-1:0] regdest_i,
  input  logic [DATA_WIDTH-1:0]     addr_i,
  input  logic [DATA_WIDTH-1:0]     wdata_i,
  output logic                      ready_o,
  output logic                      rf_wb_we_o,
  output logic [REG_ADDR_WIDTH-1:0] rf_wb_addr_o,
  output logic [DATA_WIDTH-1:0]     rf_wb_data_o,
  output logic                      misaligned_o,
  output logic                      bus_err_o,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  input  logic                      data_rvalid_i,
  output logic                      data_we_o,
  output logic [3:0]                data_be_o,
  output logic [DATA_WIDTH-1:0]     data_addr_o,
  output logic [DATA_WIDTH-1:0]     data_wdata_o,
  input  logic [DATA_WIDTH-1:0]     data_rdata_i,
  input  logic                      data_err_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;

  logic [1:0]                state;
  logic [1:0]                state_next;
  logic                      accept;
  logic                      misaligned;
  logic                      complete;
  logic [3:0]                be_new;
  logic [DATA_WIDTH-1:0]     wdata_new;

  // Operation context captured at accept, used when the response returns
  logic                      store_q;
  logic                      unsigned_q;
  logic [1:0]                size_q;
  logic [1:0]                offset_q;
  logic [REG_ADDR_WIDTH-1:0] regdest_q;

  logic [DATA_WIDTH-1:0]     rdata_shifted;
  logic [DATA_WIDTH-1:0]     load_result;

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; misaligned accesses never leave IDLE
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !misaligned) state_next = REQ;
      REQ:     if (data_gnt_i)            state_next = WAIT;
      WAIT:    if (data_rvalid_i)         state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: ready is the only output decoded straight from state
  always_comb begin
    ready_o  = (state == IDLE);
    accept   = ctrl_valid_i && (state == IDLE);
    complete = data_rvalid_i && (state == WAIT);
  end

  // Alignment check on the offered operation; size 11 behaves as a word
  always_comb begin
    misaligned = 1'b0;
    case (ctrl_i[1:0])
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = addr_i[0];
      default:   misaligned = |addr_i[1:0];
    endcase
  end

  // Byte-lane steering for the outgoing bus fields
  always_comb begin
    be_new    = 4'b1111;
    wdata_new = wdata_i << {addr_i[1:0], 3'b000};
    case (ctrl_i[1:0])
      SIZE_BYTE: be_new = 4'b0001 << addr_i[1:0];
      SIZE_HALF: be_new = 4'b0011 << addr_i[1:0];
      default:   be_new = 4'b1111;
    endcase
  end

  // Load alignment and sign/zero extension; the unsigned bit is moot for words
  always_comb begin
    rdata_shifted = data_rdata_i >> {offset_q, 3'b000};
    load_result   = rdata_shifted;
    case (size_q)
      SIZE_BYTE: load_result = unsigned_q
                   ? {{(DATA_WIDTH-8){1'b0}}, rdata_shifted[7:0]}
                   : {{(DATA_WIDTH-8){rdata_shifted[7]}}, rdata_shifted[7:0]};
      SIZE_HALF: load_result = unsigned_q
                   ? {{(DATA_WIDTH-16){1'b0}}, rdata_shifted[15:0]}
                   : {{(DATA_WIDTH-16){rdata_shifted[15]}}, rdata_shifted[15:0]};
      default:   load_result = rdata_shifted;
    endcase
  end

  // Capture operation context and bus fields on accept; held until the next accept
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      store_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      size_q       <= 2'b00;
      offset_q     <= 2'b00;
      regdest_q    <= '0;
      data_we_o    <= 1'b0;
      data_be_o    <= 4'b0000;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
    end else if (accept) begin
      store_q      <= ctrl_i[3];
      unsigned_q   <= ctrl_i[2];
      size_q       <= ctrl_i[1:0];
      offset_q     <= addr_i[1:0];
      regdest_q    <= regdest_i;
      data_we_o    <= ctrl_i[3];
      data_be_o    <= be_new;
      data_addr_o  <= {addr_i[DATA_WIDTH-1:2], 2'b00};
      data_wdata_o <= wdata_new;
    end
  end

  // Bus request follows the registered state so it is glitch-free
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      data_req_o <= 1'b0;
    end else begin
      data_req_o <= (state_next == REQ);
    end
  end

  // One-cycle status pulses and register writeback
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      misaligned_o <= 1'b0;
      bus_err_o    <= 1'b0;
      rf_wb_we_o   <= 1'b0;
      rf_wb_addr_o <= '0;
      rf_wb_data_o <= '0;
    end else begin
      misaligned_o <= accept && misaligned;
      bus_err_o    <= complete && data_err_i;
      rf_wb_we_o   <= complete && !data_err_i && !store_q && (regdest_q != '0);
      if (complete) begin
        rf_wb_addr_o <= regdest_q;
        rf_wb_data_o <= load_result;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jedro_1_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_jedro_1_lsu
// Brief    : Self-checking bench for jedro_1_lsu: directed vector table,
//            reset-during-operation sequences and randomized operations
//            compared against a byte-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jedro_1_lsu;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        ctrl_valid_i;
  logic [3:0]  ctrl_i;
  logic [4:0]  regdest_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        ready_o;
  logic        rf_wb_we_o;
  logic [4:0]  rf_wb_addr_o;
  logic [31:0] rf_wb_data_o;
  logic        misaligned_o;
  logic        bus_err_o;
  logic        data_req_o;
  logic        data_gnt_i;
  logic        data_rvalid_i;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_addr_o;
  logic [31:0] data_wdata_o;
  logic [31:0] data_rdata_i;
  logic        data_err_i;

  int n_checks = 0;
  int n_fail   = 0;

  jedro_1_lsu #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .ctrl_valid_i  (ctrl_valid_i),
    .ctrl_i        (ctrl_i),
    .regdest_i     (regdest_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .ready_o       (ready_o),
    .rf_wb_we_o    (rf_wb_we_o),
    .rf_wb_addr_o  (rf_wb_addr_o),
    .rf_wb_data_o  (rf_wb_data_o),
    .misaligned_o  (misaligned_o),
    .bus_err_o     (bus_err_o),
    .data_req_o    (data_req_o),
    .data_gnt_i    (data_gnt_i),
    .data_rvalid_i (data_rvalid_i),
    .data_we_o     (data_we_o),
    .data_be_o     (data_be_o),
    .data_addr_o   (data_addr_o),
    .data_wdata_o  (data_wdata_o),
    .data_rdata_i  (data_rdata_i),
    .data_err_i    (data_err_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        store;
    logic        uns;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [31:0] rdata;
    logic        err;
    int          gnt_dly;
    int          rv_dly;
    logic        spur;
  } op_t;

  typedef struct {
    logic        mis;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic        wb;
    logic [31:0] wbdata;
    logic        berr;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t ex;
  } vec_t;

  vec_t tbl[$];

  function automatic op_t mk_op(logic st, logic un, logic [1:0] sz, logic [31:0] ad,
                                logic [31:0] wd, logic [4:0] rd, logic [31:0] rdat,
                                logic er, int gd, int rvd);
    op_t o;
    o.store = st; o.uns = un; o.size = sz; o.addr = ad; o.wdata = wd;
    o.rd = rd; o.rdata = rdat; o.err = er; o.gnt_dly = gd; o.rv_dly = rvd;
    o.spur = 1'b0;
    return o;
  endfunction

  function automatic exp_t mk_exp(logic mi, logic [3:0] be, logic [31:0] ba,
                                  logic [31:0] bw, logic wb, logic [31:0] wbd, logic be_err);
    exp_t e;
    e.mis = mi; e.be = be; e.baddr = ba; e.bwdata = bw;
    e.wb = wb; e.wbdata = wbd; e.berr = be_err;
    return e;
  endfunction

  // Behavioural model: bytes, lanes and integer arithmetic
  function automatic exp_t model(op_t op);
    exp_t           e;
    int             nb;
    int             off;
    longint         r;
    longint         modv;
    longint         sv;
    logic [31:0]    scale;
    nb   = (op.size == 2'b00) ? 1 : (op.size == 2'b01) ? 2 : 4;
    off  = int'(op.addr % 4);
    e.mis   = (op.addr % nb) != 0;
    e.baddr = op.addr - off;
    e.be    = 4'b0000;
    for (int k = 0; k < nb; k++) if (off + k < 4) e.be[off + k] = 1'b1;
    scale = 32'd1;
    repeat (off) scale = scale * 32'd256;
    e.bwdata = op.wdata * scale;
    r = longint'(op.rdata);
    repeat (off) r = r / 256;
    modv = 1;
    repeat (nb) modv = modv * 256;
    r  = r % modv;
    sv = r;
    if (!op.uns && nb < 4 && r >= modv / 2) sv = r - modv;
    e.wbdata = sv[31:0];
    e.wb     = !e.mis && !op.store && !op.err && (op.rd != 5'd0);
    e.berr   = !e.mis && op.err;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Drives one operation from accept to completion, checking every cycle.
  // Entered and left 1 time unit after a rising edge.
  task automatic run_op(input op_t op, input exp_t e, input string tag);
    chk({tag, ".ready_idle"}, ready_o, 1);
    ctrl_valid_i = 1'b1;
    ctrl_i       = {op.store, op.uns, op.size};
    regdest_i    = op.rd;
    addr_i       = op.addr;
    wdata_i      = op.wdata;
    next_cycle();
    ctrl_valid_i = op.spur;
    ctrl_i       = 4'($urandom);
    addr_i       = $urandom;
    wdata_i      = $urandom;
    regdest_i    = 5'($urandom);
    chk({tag, ".mis"}, misaligned_o, e.mis);
    if (e.mis) begin
      ctrl_valid_i = 1'b0;
      chk({tag, ".mis_noreq"}, data_req_o, 0);
      chk({tag, ".mis_ready"}, ready_o, 1);
      return;
    end
    chk({tag, ".req"}, data_req_o, 1);
    chk({tag, ".addr"}, data_addr_o, e.baddr);
    chk({tag, ".be"}, data_be_o, e.be);
    chk({tag, ".we"}, data_we_o, op.store);
    chk({tag, ".wdata"}, data_wdata_o, e.bwdata);
    for (int i = 0; i < op.gnt_dly; i++) begin
      data_gnt_i    = 1'b0;
      data_rvalid_i = op.spur;
      next_cycle();
      chk({tag, ".req_hold"}, data_req_o, 1);
      chk({tag, ".addr_hold"}, data_addr_o, e.baddr);
      chk({tag, ".wdata_hold"}, data_wdata_o, e.bwdata);
      chk({tag, ".be_hold"}, data_be_o, e.be);
      chk({tag, ".busy"}, ready_o, 0);
    end
    data_gnt_i    = 1'b1;
    data_rvalid_i = op.spur;
    next_cycle();
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    chk({tag, ".req_drop"}, data_req_o, 0);
    chk({tag, ".wait_busy"}, ready_o, 0);
    chk({tag, ".no_early_wb"}, rf_wb_we_o, 0);
    for (int i = 0; i < op.rv_dly; i++) begin
      next_cycle();
      chk({tag, ".wait_wb"}, rf_wb_we_o, 0);
      chk({tag, ".wait_ready"}, ready_o, 0);
    end
    ctrl_valid_i  = 1'b0;
    data_rvalid_i = 1'b1;
    data_rdata_i  = op.rdata;
    data_err_i    = op.err;
    next_cycle();
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    data_rdata_i  = $urandom;
    chk({tag, ".wb_we"}, rf_wb_we_o, e.wb);
    chk({tag, ".bus_err"}, bus_err_o, e.berr);
    chk({tag, ".done_ready"}, ready_o, 1);
    if (e.wb) begin
      chk({tag, ".wb_addr"}, rf_wb_addr_o, op.rd);
      chk({tag, ".wb_data"}, rf_wb_data_o, e.wbdata);
    end
  endtask

  initial begin
    op_t  rop;
    exp_t rex;

    rstn_i        = 1'b0;
    ctrl_valid_i  = 1'b0;
    ctrl_i        = 4'd0;
    regdest_i     = 5'd0;
    addr_i        = 32'd0;
    wdata_i       = 32'd0;
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_rdata_i  = 32'd0;
    data_err_i    = 1'b0;

    // Reset values
    #12;
    chk("rst.ready", ready_o, 1);
    chk("rst.req", data_req_o, 0);
    chk("rst.we", data_we_o, 0);
    chk("rst.be", data_be_o, 0);
    chk("rst.addr", data_addr_o, 0);
    chk("rst.wdata", data_wdata_o, 0);
    chk("rst.wb_we", rf_wb_we_o, 0);
    chk("rst.wb_addr", rf_wb_addr_o, 0);
    chk("rst.wb_data", rf_wb_data_o, 0);
    chk("rst.mis", misaligned_o, 0);
    chk("rst.berr", bus_err_o, 0);
    @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    next_cycle();

    // Directed vectors, run back-to-back so each follows the previous immediately
    tbl.push_back('{mk_op(1, 0, 2'b10, 32'h100, 32'hDEADBEEF, 5'd0, 32'h0, 0, 2, 1),
                    mk_exp(0, 4'b1111, 32'h100, 32'hDEADBEEF, 0, 32'h0, 0)});
    tbl.push_back('{mk_op(1, 0, 2'b00, 32'h102, 32'h000000AB, 5'd0, 32'h0, 0, 0, 0),
                    mk_exp(0, 4'b0100, 32'h100, 32'h00AB0000, 0, 32'h0, 0)});
    tbl.push_back('{mk_op(0, 0, 2'b00, 32'h103, 32'h0, 5'd5, 32'h80FF1234, 0, 1, 0),
                    mk_exp(0, 4'b1000, 32'h100, 32'h0, 1, 32'hFFFFFF80, 0)});
    tbl.push_back('{mk_op(0, 1, 2'b01, 32'h102, 32'h0, 5'd7, 32'hBEEF0000, 0, 0, 2),
                    mk_exp(0, 4'b1100, 32'h100, 32'h0, 1, 32'h0000BEEF, 0)});
    tbl.push_back('{mk_op(0, 1, 2'b01, 32'h102, 32'h0, 5'd0, 32'hBEEF0000, 0, 0, 0),
                    mk_exp(0, 4'b1100, 32'h100, 32'h0, 0, 32'h0, 0)});
    tbl.push_back('{mk_op(0, 0, 2'b10, 32'h101, 32'h0, 5'd9, 32'h0, 0, 0, 0),
                    mk_exp(1, 4'b0000, 32'h0, 32'h0, 0, 32'h0, 0)});
    tbl.push_back('{mk_op(0, 0, 2'b10, 32'h104, 32'h0, 5'd9, 32'h13579BDF, 0, 0, 0),
                    mk_exp(0, 4'b1111, 32'h104, 32'h0, 1, 32'h13579BDF, 0)});
    tbl.push_back('{mk_op(0, 0, 2'b10, 32'h200, 32'h0, 5'd3, 32'h12345678, 1, 1, 1),
                    mk_exp(0, 4'b1111, 32'h200, 32'h0, 0, 32'h0, 1)});
    tbl.push_back('{mk_op(0, 0, 2'b01, 32'h100, 32'h0, 5'd10, 32'h12348001, 0, 0, 0),
                    mk_exp(0, 4'b0011, 32'h100, 32'h0, 1, 32'hFFFF8001, 0)});
    tbl.push_back('{mk_op(0, 1, 2'b00, 32'h101, 32'h0, 5'd11, 32'h0000F000, 0, 0, 0),
                    mk_exp(0, 4'b0010, 32'h100, 32'h0, 1, 32'h000000F0, 0)});
    tbl.push_back('{mk_op(0, 0, 2'b01, 32'h103, 32'h0, 5'd4, 32'h0, 0, 0, 0),
                    mk_exp(1, 4'b0000, 32'h0, 32'h0, 0, 32'h0, 0)});
    tbl.push_back('{mk_op(0, 1, 2'b11, 32'h104, 32'h0, 5'd31, 32'hCAFEF00D, 0, 0, 0),
                    mk_exp(0, 4'b1111, 32'h104, 32'h0, 1, 32'hCAFEF00D, 0)});
    tbl.push_back('{mk_op(1, 0, 2'b01, 32'h102, 32'h00001234, 5'd0, 32'h0, 0, 0, 0),
                    mk_exp(0, 4'b1100, 32'h100, 32'h12340000, 0, 32'h0, 0)});
    tbl.push_back('{mk_op(1, 0, 2'b10, 32'h102, 32'h11111111, 5'd0, 32'h0, 0, 0, 0),
                    mk_exp(1, 4'b0000, 32'h0, 32'h0, 0, 32'h0, 0)});
    tbl.push_back('{mk_op(1, 0, 2'b00, 32'h300, 32'h00000055, 5'd0, 32'h0, 1, 0, 0),
                    mk_exp(0, 4'b0001, 32'h300, 32'h00000055, 0, 32'h0, 1)});

    foreach (tbl[i]) run_op(tbl[i].op, tbl[i].ex, $sformatf("vec%0d", i));
    next_cycle();
    chk("vec.pulse_end_wb", rf_wb_we_o, 0);
    chk("vec.pulse_end_berr", bus_err_o, 0);

    // Reset while requesting: request drops without a clock edge
    ctrl_valid_i = 1'b1;
    ctrl_i       = 4'b0010;
    regdest_i    = 5'd4;
    addr_i       = 32'h400;
    next_cycle();
    ctrl_valid_i = 1'b0;
    chk("rstreq.req_before", data_req_o, 1);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("rstreq.req", data_req_o, 0);
    chk("rstreq.ready", ready_o, 1);
    next_cycle();
    rstn_i = 1'b1;
    next_cycle();

    // Reset while waiting: pending response is discarded
    ctrl_valid_i = 1'b1;
    ctrl_i       = 4'b0010;
    regdest_i    = 5'd6;
    addr_i       = 32'h404;
    next_cycle();
    ctrl_valid_i = 1'b0;
    data_gnt_i   = 1'b1;
    next_cycle();
    data_gnt_i   = 1'b0;
    chk("rstwait.in_wait", ready_o, 0);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("rstwait.ready", ready_o, 1);
    chk("rstwait.req", data_req_o, 0);
    next_cycle();
    rstn_i        = 1'b1;
    data_rvalid_i = 1'b1;
    data_rdata_i  = 32'h55AA55AA;
    next_cycle();
    data_rvalid_i = 1'b0;
    chk("rstwait.no_wb", rf_wb_we_o, 0);
    chk("rstwait.no_berr", bus_err_o, 0);
    chk("rstwait.ready_after", ready_o, 1);
    run_op(mk_op(0, 0, 2'b00, 32'h406, 32'h0, 5'd6, 32'h00420000, 0, 0, 0),
           mk_exp(0, 4'b0100, 32'h404, 32'h0, 1, 32'h00000042, 0), "rstwait.next");

    // Randomized operations against the model
    for (int i = 0; i < 200; i++) begin
      rop.store   = 1'($urandom);
      rop.uns     = 1'($urandom);
      rop.size    = 2'($urandom);
      rop.addr    = $urandom;
      rop.wdata   = $urandom;
      rop.rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      rop.rdata   = $urandom;
      rop.err     = ($urandom_range(0, 7) == 0);
      rop.gnt_dly = $urandom_range(0, 3);
      rop.rv_dly  = $urandom_range(0, 3);
      rop.spur    = 1'($urandom);
      if (rop.store) rop.wdata = rop.wdata & ((rop.size == 2'b00) ? 32'hFF :
                                             (rop.size == 2'b01) ? 32'hFFFF : 32'hFFFFFFFF);
      rex = model(rop);
      run_op(rop, rex, $sformatf("rnd%0d", i));
      repeat ($urandom_range(0, 2)) begin
        ctrl_i = 4'($urandom);
        addr_i = $urandom;
        next_cycle();
        chk($sformatf("rnd%0d.idle_quiet", i), data_req_o | rf_wb_we_o | bus_err_o, 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
